vx_axi_burst_adapter: RTL and testbench

// - Bridges the Vortex memory request/response interface to an AXI4 master port whose data bus is

---
 rtl/vx_axi_burst_adapter.sv | 249 ++++++++++++++++++++++++
 tb/tb_vx_axi_burst_adapter.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vx_axi_burst_adapter.sv
// Vortex line request/response to AXI4 burst master bridge.
// Each line becomes one INCR burst of BEATS beats; read beats are gathered into a single line response.
module vx_axi_burst_adapter #(
  parameter int unsigned VX_DATA_WIDTH  = 512,
  parameter int unsigned VX_ADDR_WIDTH  = 26,
  parameter int unsigned VX_TAG_WIDTH   = 8,
  parameter int unsigned AXI_DATA_WIDTH = 128,
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned MAX_READS      = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,

  input  logic                          mem_req_valid,
  output logic                          mem_req_ready,
  input  logic                          mem_req_rw,
  input  logic [VX_DATA_WIDTH/8-1:0]    mem_req_byteen,
  input  logic [VX_ADDR_WIDTH-1:0]      mem_req_addr,
  input  logic [VX_DATA_WIDTH-1:0]      mem_req_data,
  input  logic [VX_TAG_WIDTH-1:0]       mem_req_tag,

  output logic                          mem_rsp_valid,
  input  logic                          mem_rsp_ready,
  output logic [VX_DATA_WIDTH-1:0]      mem_rsp_data,
  output logic [VX_TAG_WIDTH-1:0]       mem_rsp_tag,

  output logic [VX_TAG_WIDTH-1:0]       m_axi_awid,
  output logic [AXI_ADDR_WIDTH-1:0]     m_axi_awaddr,
  output logic [7:0]                    m_axi_awlen,
  output logic [2:0]                    m_axi_awsize,
  output logic [1:0]                    m_axi_awburst,
  output logic                          m_axi_awlock,
  output logic [3:0]                    m_axi_awcache,
  output logic [2:0]                    m_axi_awprot,
  output logic [3:0]                    m_axi_awqos,
  output logic                          m_axi_awvalid,
  input  logic                          m_axi_awready,

  output logic [AXI_DATA_WIDTH-1:0]     m_axi_wdata,
  output logic [AXI_DATA_WIDTH/8-1:0]   m_axi_wstrb,
  output logic                          m_axi_wlast,
  output logic                          m_axi_wvalid,
  input  logic                          m_axi_wready,

  input  logic [VX_TAG_WIDTH-1:0]       m_axi_bid,
  input  logic [1:0]                    m_axi_bresp,
  input  logic                          m_axi_bvalid,
  output logic                          m_axi_bready,

  output logic [VX_TAG_WIDTH-1:0]       m_axi_arid,
  output logic [AXI_ADDR_WIDTH-1:0]     m_axi_araddr,
  output logic [7:0]                    m_axi_arlen,
  output logic [2:0]                    m_axi_arsize,
  output logic [1:0]                    m_axi_arburst,
  output logic                          m_axi_arlock,
  output logic [3:0]                    m_axi_arcache,
  output logic [2:0]                    m_axi_arprot,
  output logic [3:0]                    m_axi_arqos,
  output logic                          m_axi_arvalid,
  input  logic                          m_axi_arready,

  input  logic [VX_TAG_WIDTH-1:0]       m_axi_rid,
  input  logic [AXI_DATA_WIDTH-1:0]     m_axi_rdata,
  input  logic [1:0]                    m_axi_rresp,
  input  logic                          m_axi_rlast,
  input  logic                          m_axi_rvalid,
  output logic                          m_axi_rready,

  output logic                          axi_error
);

  localparam int unsigned BEATS      = VX_DATA_WIDTH / AXI_DATA_WIDTH;
  localparam int unsigned STRB_W     = AXI_DATA_WIDTH / 8;
  localparam int unsigned BEAT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned CNT_W      = $clog2(MAX_READS + 1);
  localparam int unsigned LINE_SHIFT = $clog2(VX_DATA_WIDTH / 8);
  localparam int unsigned AXSIZE     = $clog2(STRB_W);

  typedef enum logic [1:0] {IDLE, WR, RD} state_t;

  state_t                               state_q;
  logic                                 active_q;
  logic [VX_ADDR_WIDTH-1:0]             addr_q;
  logic [VX_TAG_WIDTH-1:0]              tag_q;
  logic [BEATS-1:0][AXI_DATA_WIDTH-1:0] data_q;
  logic [BEATS-1:0][STRB_W-1:0]         strb_q;
  logic [BEAT_W-1:0]                    wk_q;
  logic                                 awvalid_q, wvalid_q, arvalid_q;

  logic [BEATS-1:0][AXI_DATA_WIDTH-1:0] line_q;
  logic [BEAT_W-1:0]                    rj_q;
  logic                                 rsp_pending_q;
  logic [VX_TAG_WIDTH-1:0]              rsp_tag_q;
  logic [CNT_W-1:0]                     rd_cnt_q;
  logic                                 err_q;

  logic req_fire, aw_fire, w_fire, ar_fire, r_fire, b_fire, rsp_fire;
  logic w_last, r_last_beat;
  logic unused_bid;

  assign mem_req_ready = active_q && (state_q == IDLE)
                         && (mem_req_rw || (rd_cnt_q < CNT_W'(MAX_READS)));

  assign req_fire    = mem_req_valid && mem_req_ready;
  assign aw_fire     = awvalid_q && m_axi_awready;
  assign w_fire      = wvalid_q && m_axi_wready;
  assign ar_fire     = arvalid_q && m_axi_arready;
  assign r_fire      = m_axi_rvalid && m_axi_rready;
  assign b_fire      = m_axi_bvalid && m_axi_bready;
  assign rsp_fire    = rsp_pending_q && mem_rsp_ready;
  assign w_last      = (wk_q == BEAT_W'(BEATS - 1));
  assign r_last_beat = (rj_q == BEAT_W'(BEATS - 1));
  assign unused_bid  = ^m_axi_bid;

  // Request FSM: one line request becomes one AW+W burst or one AR.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      active_q  <= 1'b0;
      addr_q    <= '0;
      tag_q     <= '0;
      wk_q      <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      arvalid_q <= 1'b0;
    end else begin
      active_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (req_fire) begin
            addr_q <= mem_req_addr;
            tag_q  <= mem_req_tag;
            wk_q   <= '0;
            if (mem_req_rw) begin
              state_q   <= WR;
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
            end else begin
              state_q   <= RD;
              arvalid_q <= 1'b1;
            end
          end
        end
        WR: begin
          if (aw_fire) awvalid_q <= 1'b0;
          if (w_fire) begin
            if (w_last) begin
              wvalid_q <= 1'b0;
              wk_q     <= '0;
            end else begin
              wk_q <= wk_q + BEAT_W'(1);
            end
          end
          // A dropped valid means that channel already finished.
          if ((aw_fire || !awvalid_q) && ((w_fire && w_last) || !wvalid_q))
            state_q <= IDLE;
        end
        RD: begin
          if (ar_fire) begin
            arvalid_q <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Write payload needs no reset; it is only observed behind wvalid.
  always_ff @(posedge clk) begin
    if (req_fire && mem_req_rw) begin
      data_q <= mem_req_data;
      strb_q <= mem_req_byteen;
    end
  end

  // Read gather, outstanding-read accounting and sticky error.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rj_q          <= '0;
      rsp_pending_q <= 1'b0;
      rsp_tag_q     <= '0;
      rd_cnt_q      <= '0;
      err_q         <= 1'b0;
    end else begin
      if (r_fire) begin
        if (r_last_beat) begin
          rsp_pending_q <= 1'b1;
          rsp_tag_q     <= m_axi_rid;
          rj_q          <= '0;
        end else begin
          rj_q <= rj_q + BEAT_W'(1);
        end
      end
      if (rsp_fire) rsp_pending_q <= 1'b0;

      if (ar_fire && !rsp_fire)
        rd_cnt_q <= rd_cnt_q + CNT_W'(1);
      else if (rsp_fire && !ar_fire)
        rd_cnt_q <= rd_cnt_q - CNT_W'(1);

      if ((b_fire && (m_axi_bresp != 2'b00)) ||
          (r_fire && ((m_axi_rresp != 2'b00) || (m_axi_rlast != r_last_beat))))
        err_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (r_fire) line_q[rj_q] <= m_axi_rdata;
  end

  assign m_axi_awid    = tag_q;
  assign m_axi_awaddr  = AXI_ADDR_WIDTH'(addr_q) << LINE_SHIFT;
  assign m_axi_awlen   = 8'(BEATS - 1);
  assign m_axi_awsize  = 3'(AXSIZE);
  assign m_axi_awburst = 2'b01;
  assign m_axi_awlock  = 1'b0;
  assign m_axi_awcache = 4'd0;
  assign m_axi_awprot  = 3'd0;
  assign m_axi_awqos   = 4'd0;
  assign m_axi_awvalid = awvalid_q;

  assign m_axi_wdata   = data_q[wk_q];
  assign m_axi_wstrb   = strb_q[wk_q];
  assign m_axi_wlast   = w_last;
  assign m_axi_wvalid  = wvalid_q;

  assign m_axi_bready  = 1'b1;

  assign m_axi_arid    = tag_q;
  assign m_axi_araddr  = AXI_ADDR_WIDTH'(addr_q) << LINE_SHIFT;
  assign m_axi_arlen   = 8'(BEATS - 1);
  assign m_axi_arsize  = 3'(AXSIZE);
  assign m_axi_arburst = 2'b01;
  assign m_axi_arlock  = 1'b0;
  assign m_axi_arcache = 4'd0;
  assign m_axi_arprot  = 3'd0;
  assign m_axi_arqos   = 4'd0;
  assign m_axi_arvalid = arvalid_q;

  assign m_axi_rready  = !rsp_pending_q;

  assign mem_rsp_valid = rsp_pending_q;
  assign mem_rsp_data  = line_q;
  assign mem_rsp_tag   = rsp_tag_q;

  assign axi_error     = err_q;

endmodule

// File: tb/tb_vx_axi_burst_adapter.sv
// Randomized self-checking bench for vx_axi_burst_adapter (512-bit line, 128-bit AXI, 4 beats).
// Expected bursts and lines are derived from the request by plain slicing and arithmetic.
module tb_vx_axi_burst_adapter;
  localparam int VXW = 512, VAW = 26, TW = 8, XW = 128, XAW = 32, MR = 4, BEATS = 4;

  typedef logic [511:0] v_t;

  logic clk, reset_n;
  logic mem_req_valid, mem_req_ready, mem_req_rw;
  logic [VXW/8-1:0] mem_req_byteen;
  logic [VAW-1:0] mem_req_addr;
  logic [VXW-1:0] mem_req_data;
  logic [TW-1:0] mem_req_tag;
  logic mem_rsp_valid, mem_rsp_ready;
  logic [VXW-1:0] mem_rsp_data;
  logic [TW-1:0] mem_rsp_tag;
  logic [TW-1:0] awid, arid, bid, rid;
  logic [XAW-1:0] awaddr, araddr;
  logic [7:0] awlen, arlen;
  logic [2:0] awsize, arsize, awprot, arprot;
  logic [1:0] awburst, arburst, bresp, rresp;
  logic awlock, arlock;
  logic [3:0] awcache, arcache, awqos, arqos;
  logic awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic arvalid, arready, rvalid, rready, rlast, axi_error;
  logic [XW-1:0] wdata, rdata;
  logic [XW/8-1:0] wstrb;

  int errs = 0;
  int checks = 0;

  vx_axi_burst_adapter #(
    .VX_DATA_WIDTH(VXW), .VX_ADDR_WIDTH(VAW), .VX_TAG_WIDTH(TW),
    .AXI_DATA_WIDTH(XW), .AXI_ADDR_WIDTH(XAW), .MAX_READS(MR)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_rw(mem_req_rw),
    .mem_req_byteen(mem_req_byteen), .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data),
    .mem_req_tag(mem_req_tag),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_ready(mem_rsp_ready), .mem_rsp_data(mem_rsp_data),
    .mem_rsp_tag(mem_rsp_tag),
    .m_axi_awid(awid), .m_axi_awaddr(awaddr), .m_axi_awlen(awlen), .m_axi_awsize(awsize),
    .m_axi_awburst(awburst), .m_axi_awlock(awlock), .m_axi_awcache(awcache), .m_axi_awprot(awprot),
    .m_axi_awqos(awqos), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
    .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wlast(wlast), .m_axi_wvalid(wvalid),
    .m_axi_wready(wready),
    .m_axi_bid(bid), .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
    .m_axi_arid(arid), .m_axi_araddr(araddr), .m_axi_arlen(arlen), .m_axi_arsize(arsize),
    .m_axi_arburst(arburst), .m_axi_arlock(arlock), .m_axi_arcache(arcache), .m_axi_arprot(arprot),
    .m_axi_arqos(arqos), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
    .m_axi_rid(rid), .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rlast(rlast),
    .m_axi_rvalid(rvalid), .m_axi_rready(rready),
    .axi_error(axi_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input v_t got, input v_t exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic v_t rnd512();
    v_t v;
    for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  // Present one request and hold it until accepted (bounded).
  task automatic send_req(input bit rw, input logic [VAW-1:0] a, input v_t d,
                          input logic [63:0] be, input logic [TW-1:0] t);
    @(negedge clk);
    mem_req_valid = 1'b1; mem_req_rw = rw; mem_req_addr = a;
    mem_req_data = d; mem_req_byteen = be; mem_req_tag = t;
    for (int i = 0; i <= 60; i++) begin
      #1;
      if (mem_req_ready) break;
      if (i == 60) check("req_timeout", v_t'(0), v_t'(1));
      @(negedge clk);
    end
    @(negedge clk);
    mem_req_valid = 1'b0;
  endtask

  task automatic expect_aw(input logic [VAW-1:0] a, input logic [TW-1:0] t, input int dly);
    for (int c = 0; c < 80; c++) begin
      awready = (c >= dly); #1;
      if (c == 0) check("awvalid_latency", v_t'(awvalid), v_t'(1));
      if (awvalid && awready) begin
        check("awaddr", v_t'(awaddr), v_t'(XAW'(a) * 64));
        check("awlen", v_t'(awlen), v_t'(BEATS - 1));
        check("awsize", v_t'(awsize), v_t'(4));
        check("awburst", v_t'(awburst), v_t'(1));
        check("awid", v_t'(awid), v_t'(t));
        @(negedge clk);
        awready = 1'b0;
        return;
      end
      check("busy_ready_aw", v_t'(mem_req_ready), v_t'(0));
      @(negedge clk);
    end
    check("aw_timeout", v_t'(0), v_t'(1));
  endtask

  task automatic expect_w(input v_t d, input logic [63:0] be, input int stall, input bit rnd);
    int k = 0;
    for (int c = 0; c < 120; c++) begin
      wready = (c >= stall) && (rnd ? ($urandom_range(0, 1) == 1) : 1'b1); #1;
      check("wvalid_held", v_t'(wvalid), v_t'(1));
      check("wdata", v_t'(wdata), v_t'(d[k*XW +: XW]));
      check("wstrb", v_t'(wstrb), v_t'(be[k*16 +: 16]));
      check("wlast", v_t'(wlast), v_t'(k == BEATS - 1));
      if (k < BEATS - 1 || !wready) check("busy_ready_w", v_t'(mem_req_ready), v_t'(0));
      if (wvalid && wready) k++;
      if (k == BEATS) begin
        @(negedge clk);
        wready = 1'b0;
        return;
      end
      @(negedge clk);
    end
    check("w_timeout", v_t'(0), v_t'(1));
  endtask

  task automatic do_write(input logic [VAW-1:0] a, input v_t d, input logic [63:0] be,
                          input logic [TW-1:0] t, input int awd, input int ws, input bit rnd);
    send_req(1'b1, a, d, be, t);
    fork
      expect_aw(a, t, awd);
      expect_w(d, be, ws, rnd);
    join
    #1;
    check("ready_after_write", v_t'(mem_req_ready), v_t'(1));
    check("no_valids_after_write", v_t'({awvalid, wvalid}), v_t'(0));
  endtask

  task automatic expect_ar(input logic [VAW-1:0] a, input logic [TW-1:0] t, input int dly);
    for (int c = 0; c < 80; c++) begin
      arready = (c >= dly); #1;
      if (c == 0) check("arvalid_latency", v_t'(arvalid), v_t'(1));
      if (arvalid && arready) begin
        check("araddr", v_t'(araddr), v_t'(XAW'(a) * 64));
        check("arlen", v_t'(arlen), v_t'(BEATS - 1));
        check("arsize", v_t'(arsize), v_t'(4));
        check("arburst", v_t'(arburst), v_t'(1));
        check("arid", v_t'(arid), v_t'(t));
        @(negedge clk);
        arready = 1'b0;
        return;
      end
      @(negedge clk);
    end
    check("ar_timeout", v_t'(0), v_t'(1));
  endtask

  task automatic r_beat(input logic [XW-1:0] d, input logic [TW-1:0] t, input bit last,
                        input logic [1:0] resp, input int gap);
    for (int g = 0; g < gap; g++) @(negedge clk);
    rvalid = 1'b1; rdata = d; rid = t; rlast = last; rresp = resp; #1;
    check("rready", v_t'(rready), v_t'(1));
    @(negedge clk);
    rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
  endtask

  task automatic deliver_rsp(input v_t line, input logic [TW-1:0] t);
    check("rsp_valid", v_t'(mem_rsp_valid), v_t'(1));
    check("rsp_data", v_t'(mem_rsp_data), line);
    check("rsp_tag", v_t'(mem_rsp_tag), v_t'(t));
    mem_rsp_ready = 1'b1;
    @(negedge clk);
    mem_rsp_ready = 1'b0;
    check("rsp_cleared", v_t'(mem_rsp_valid), v_t'(0));
  endtask

  // Return a full burst; the expected line is the beats concatenated low to high.
  task automatic return_burst(input logic [TW-1:0] t, input int gap);
    logic [XW-1:0] q[$];
    v_t line;
    for (int j = 0; j < BEATS; j++) begin
      q.push_back({$urandom(), $urandom(), $urandom(), $urandom()});
      check("rsp_early", v_t'(mem_rsp_valid), v_t'(0));
      r_beat(q[j], t, j == BEATS - 1, 2'b00, gap);
    end
    line = '0;
    foreach (q[j]) line[j*XW +: XW] = q[j];
    deliver_rsp(line, t);
  endtask

  task automatic do_read(input logic [VAW-1:0] a, input logic [TW-1:0] t,
                         input int ard, input int gap);
    send_req(1'b0, a, '0, '0, t);
    expect_ar(a, t, ard);
    return_burst(t, gap);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #2 reset_n = 1'b0; #1;
    check("rst_err", v_t'(axi_error), v_t'(0));
    check("rst_valids", v_t'({awvalid, wvalid, arvalid, mem_rsp_valid}), v_t'(0));
    check("rst_req_ready", v_t'(mem_req_ready), v_t'(0));
    rvalid = 1'b0; bvalid = 1'b0; awready = 1'b0; wready = 1'b0; arready = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    logic [TW-1:0] tg[5];
    logic [VAW-1:0] ad[5];
    reset_n = 1'b0;
    mem_req_valid = 0; mem_req_rw = 0; mem_req_byteen = '0; mem_req_addr = '0;
    mem_req_data = '0; mem_req_tag = '0; mem_rsp_ready = 0;
    awready = 0; wready = 0; arready = 0;
    bid = '0; bresp = '0; bvalid = 0;
    rid = '0; rdata = '0; rresp = '0; rlast = 0; rvalid = 0;

    #12;
    check("reset_req_ready", v_t'(mem_req_ready), v_t'(0));
    check("reset_valids", v_t'({awvalid, wvalid, arvalid, mem_rsp_valid}), v_t'(0));
    check("reset_err", v_t'(axi_error), v_t'(0));
    check("bready", v_t'(bready), v_t'(1));
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Directed write, ready always high.
    do_write(26'h10, rnd512(), {64{1'b1}}, 8'h11, 0, 0, 1'b0);
    // Stalled write: wready low 5 cycles, awready after 7.
    do_write(26'h2345, rnd512(), {$urandom(), $urandom()}, 8'h22, 7, 5, 1'b0);
    for (int i = 0; i < 6; i++)
      do_write(VAW'($urandom()), rnd512(), {$urandom(), $urandom()}, TW'($urandom()),
               $urandom_range(0, 6), $urandom_range(0, 4), 1'b1);

    // Directed read with 2-cycle gaps between beats, then randomized reads.
    do_read(26'h2, 8'h5A, 0, 2);
    for (int i = 0; i < 6; i++)
      do_read(VAW'($urandom()), TW'($urandom()), $urandom_range(0, 4), $urandom_range(0, 3));

    // Outstanding-read bound: 4 ARs accepted, 5th blocked until one line is delivered.
    for (int i = 0; i < 5; i++) begin
      tg[i] = TW'($urandom()); ad[i] = VAW'($urandom());
    end
    for (int i = 0; i < MR; i++) begin
      send_req(1'b0, ad[i], '0, '0, tg[i]);
      expect_ar(ad[i], tg[i], 0);
    end
    @(negedge clk);
    mem_req_valid = 1'b1; mem_req_rw = 1'b0; mem_req_addr = ad[4]; mem_req_tag = tg[4];
    for (int c = 0; c < 4; c++) begin
      #1;
      check("rd_blocked", v_t'(mem_req_ready), v_t'(0));
      check("no_5th_ar", v_t'(arvalid), v_t'(0));
      @(negedge clk);
    end
    return_burst(tg[0], 1);
    #1;
    check("rd_unblocked", v_t'(mem_req_ready), v_t'(1));
    @(negedge clk);
    mem_req_valid = 1'b0;
    expect_ar(ad[4], tg[4], 0);

    // Reset in the middle of a write drops it.
    send_req(1'b1, 26'h77, rnd512(), '1, 8'h33);
    @(negedge clk);
    pulse_reset();
    mem_req_rw = 1'b0; #1;
    check("rd_cnt_cleared", v_t'(mem_req_ready), v_t'(1));

    // B response errors.
    do_write(26'h5, rnd512(), '1, 8'h44, 0, 0, 1'b0);
    bvalid = 1'b1; bresp = 2'b00; bid = 8'h44;
    @(negedge clk);
    check("bresp_ok", v_t'(axi_error), v_t'(0));
    bresp = 2'b10;
    @(negedge clk);
    bvalid = 1'b0; bresp = 2'b00;
    check("bresp_err", v_t'(axi_error), v_t'(1));
    pulse_reset();

    // RRESP error is sticky; reset mid-burst clears it.
    send_req(1'b0, 26'h9, '0, '0, 8'h66);
    expect_ar(26'h9, 8'h66, 0);
    r_beat(128'h1, 8'h66, 1'b0, 2'b10, 0);
    check("rresp_err", v_t'(axi_error), v_t'(1));
    r_beat(128'h2, 8'h66, 1'b0, 2'b00, 1);
    check("err_sticky", v_t'(axi_error), v_t'(1));
    pulse_reset();

    // Early RLAST on beat 1.
    send_req(1'b0, 26'hA, '0, '0, 8'h67);
    expect_ar(26'hA, 8'h67, 0);
    r_beat(128'h3, 8'h67, 1'b0, 2'b00, 0);
    check("no_err_yet", v_t'(axi_error), v_t'(0));
    r_beat(128'h4, 8'h67, 1'b1, 2'b00, 0);
    check("rlast_err", v_t'(axi_error), v_t'(1));
    r_beat(128'h5, 8'h67, 1'b0, 2'b00, 0);
    r_beat(128'h6, 8'h67, 1'b1, 2'b00, 0);
    deliver_rsp({128'h6, 128'h5, 128'h4, 128'h3}, 8'h67);
    check("err_still_set", v_t'(axi_error), v_t'(1));
    pulse_reset();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end
endmodule
